// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: controller state
// encoding and the hard-wired zero register number.
package hazard_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DSTALL = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DSTALL = ST_DSTALL,
    FREEZE = ST_FREEZE
  } hz_state_e;

  // Register $0 is hard-wired to zero, so it never carries a dependency.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_reg_match.sv
// Compares one producer destination against the source operands of the
// instruction in ID. Writes to $0 never create a dependency, and rt only
// matters when the ID instruction actually reads it.
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] dst,
  input  logic              valid,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rt,
  output logic              hit
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  assign dst_nonzero = (dst != REG_AW'(ZERO_REG));
  assign rs_match    = (dst == rs);
  assign rt_match    = use_rt & (dst == rt);
  assign hit         = valid & dst_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline. Detects load-use and
// branch-in-ID operand hazards, sequences multi-cycle load stalls, freezes
// the pipe on cache misses and counts cycles in which the PC was held.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_IN_ID = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic [REG_AW-1:0] idex_dst,
  input  logic              exmem_memread,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rt,
  input  logic              ifid_branch,
  input  logic              pc_redirect,
  input  logic              mem_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int RW = $clog2(LOAD_LAT + 2);
  localparam logic BR_EN = (BR_IN_ID != 0);

  // Index 0 watches the EX stage producer, index 1 the MEM stage load.
  logic [REG_AW-1:0] src_dst   [2];
  logic              src_valid [2];
  logic              src_hit   [2];

  assign src_dst[0]   = idex_dst;
  assign src_valid[0] = idex_memread | idex_regwrite;
  assign src_dst[1]   = exmem_dst;
  assign src_valid[1] = exmem_memread;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      hazard_reg_match #(
        .REG_AW (REG_AW)
      ) u_match (
        .dst    (src_dst[gi]),
        .valid  (src_valid[gi]),
        .rs     (ifid_rs),
        .rt     (ifid_rt),
        .use_rt (ifid_use_rt),
        .hit    (src_hit[gi])
      );
    end
  endgenerate

  logic lu_haz;
  logic br_haz;
  logic br_extra;

  assign lu_haz   = idex_memread & src_hit[0];
  assign br_haz   = BR_EN & ifid_branch & ((idex_regwrite & src_hit[0]) | src_hit[1]);
  assign br_extra = BR_EN & ifid_branch;

  // Stall cycles owed after the detection cycle of a load-use hazard; a
  // branch consuming a load needs one more because it reads in ID.
  logic [RW-1:0] lu_extra;
  assign lu_extra = RW'(LOAD_LAT - 1) + RW'(br_extra);

  hz_state_e        state_reg;
  logic [RW-1:0]    remain_reg;   // DSTALL cycles still owed, minus one
  logic             resume_reg;   // 1: leave FREEZE into DSTALL, 0: into RUN
  logic [CNT_W-1:0] cnt_reg;

  logic freeze_now;
  logic stall_now;

  assign freeze_now = (state_reg == FREEZE) | mem_stall;
  assign stall_now  = (state_reg == DSTALL) | ((state_reg == RUN) & (lu_haz | br_haz));

  // Pipeline enables: reset forcing, then freeze > data stall > redirect.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = pc_redirect;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze_now) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (stall_now) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Stall sequencer and saturating held-PC counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      remain_reg <= '0;
      resume_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if (!pc_write && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      case (state_reg)
        RUN: begin
          if (mem_stall) begin
            state_reg  <= FREEZE;
            resume_reg <= 1'b0;
          end else if (lu_haz && (lu_extra != '0)) begin
            // The detection cycle is itself a bubble, so only the
            // remaining cycles are sequenced from DSTALL.
            state_reg  <= DSTALL;
            remain_reg <= lu_extra - RW'(1);
          end
        end
        DSTALL: begin
          if (mem_stall) begin
            state_reg  <= FREEZE;
            resume_reg <= 1'b1;
          end else if (remain_reg == '0) begin
            state_reg <= RUN;
          end else begin
            remain_reg <= remain_reg - RW'(1);
          end
        end
        FREEZE: begin
          if (!mem_stall) begin
            state_reg <= resume_reg ? DSTALL : RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign stall_cycles = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: three parameterisations share the
// same stimulus, a bubble-count reference model queues expected outputs and
// a negedge monitor compares them.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0, idex_regwrite = 1'b0;
  logic [4:0] idex_dst = '0, exmem_dst = '0, ifid_rs = '0, ifid_rt = '0;
  logic       exmem_memread = 1'b0, ifid_use_rt = 1'b0, ifid_branch = 1'b0;
  logic       pc_redirect = 1'b0, mem_stall = 1'b0;

  always #5 clk = ~clk;

  logic        pw [3], iw [3], fl [3], bb [3], fzo [3];
  logic [15:0] sc0;
  logic [3:0]  sc1;
  logic [5:0]  sc2;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .BR_IN_ID(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dst(idex_dst), .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt), .ifid_branch(ifid_branch),
    .pc_redirect(pc_redirect), .mem_stall(mem_stall), .pc_write(pw[0]), .ifid_write(iw[0]),
    .ifid_flush(fl[0]), .idex_bubble(bb[0]), .pipe_freeze(fzo[0]), .stall_cycles(sc0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .BR_IN_ID(1), .CNT_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dst(idex_dst), .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt), .ifid_branch(ifid_branch),
    .pc_redirect(pc_redirect), .mem_stall(mem_stall), .pc_write(pw[1]), .ifid_write(iw[1]),
    .ifid_flush(fl[1]), .idex_bubble(bb[1]), .pipe_freeze(fzo[1]), .stall_cycles(sc1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .BR_IN_ID(0), .CNT_W(6)) u_d2 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_dst(idex_dst), .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt), .ifid_branch(ifid_branch),
    .pc_redirect(pc_redirect), .mem_stall(mem_stall), .pc_write(pw[2]), .ifid_write(iw[2]),
    .ifid_flush(fl[2]), .idex_bubble(bb[2]), .pipe_freeze(fzo[2]), .stall_cycles(sc2));

  logic [15:0] sc_act [3];
  assign sc_act[0] = sc0;
  assign sc_act[1] = {12'b0, sc1};
  assign sc_act[2] = {10'b0, sc2};

  // Expected outputs per cycle; ctl = {pc_write, ifid_write, flush, bubble, freeze}
  typedef struct packed {
    logic [2:0][4:0]  ctl;
    logic [2:0][15:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model parameters and state per instance.
  int lat_p  [3] = '{1, 3, 2};
  int brid_p [3] = '{1, 1, 0};
  int cmax_p [3] = '{65535, 15, 63};
  int bubbles_left [3];
  bit frozen [3];
  int cnt_m [3];

  function automatic bit src_match(logic [4:0] d, logic [4:0] rs, logic [4:0] rt, bit urt);
    return (d != 5'd0) && ((d == rs) || (urt && (d == rt)));
  endfunction

  // One clock cycle of stimulus; the model computes this cycle's outputs,
  // queues them, then advances its own state across the coming edge.
  task automatic cyc(input bit rn, input bit ms, input bit imr, input bit irw,
                     input logic [4:0] idst, input bit emr, input logic [4:0] edst,
                     input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                     input bit br, input bit redir);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; mem_stall = ms; idex_memread = imr; idex_regwrite = irw; idex_dst = idst;
    exmem_memread = emr; exmem_dst = edst; ifid_rs = rs; ifid_rt = rt;
    ifid_use_rt = urt; ifid_branch = br; pc_redirect = redir;
    for (int k = 0; k < 3; k++) begin
      bit lu, brh;
      logic [4:0] c;
      e.cnt[k] = 16'(cnt_m[k]);
      lu  = imr && src_match(idst, rs, rt, urt);
      brh = (brid_p[k] != 0) && br &&
            ((irw && src_match(idst, rs, rt, urt)) || (emr && src_match(edst, rs, rt, urt)));
      if (!rn) begin
        c = 5'b00110;
        bubbles_left[k] = 0; frozen[k] = 1'b0;
      end else if (frozen[k] || ms) begin
        c = 5'b00001;
        frozen[k] = ms;
      end else if (bubbles_left[k] > 0) begin
        c = 5'b00010;
        bubbles_left[k]--;
      end else if (lu || brh) begin
        c = 5'b00010;
        bubbles_left[k] = lu ? (lat_p[k] - 1 + ((brid_p[k] != 0 && br) ? 1 : 0)) : 0;
      end else begin
        c = {1'b1, 1'b1, redir, 1'b0, 1'b0};
      end
      e.ctl[k] = c;
      if (!rn) cnt_m[k] = 0;
      else if (!c[4] && cnt_m[k] < cmax_p[k]) cnt_m[k]++;
    end
    sb_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({pw[k], iw[k], fl[k], bb[k], fzo[k]} !== mon_e.ctl[k]) begin
          n_errors++;
          $display("FAIL ctl dut%0d t=%0t got=%b want=%b", k, $time,
                   {pw[k], iw[k], fl[k], bb[k], fzo[k]}, mon_e.ctl[k]);
        end
        n_checks++;
        if (sc_act[k] !== mon_e.cnt[k]) begin
          n_errors++;
          $display("FAIL stall_cycles dut%0d t=%0t got=%0d want=%0d", k, $time,
                   sc_act[k], mon_e.cnt[k]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      bubbles_left[k] = 0; frozen[k] = 1'b0; cnt_m[k] = 0;
    end

    $display("txn: reset");
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    nop(2);

    $display("txn: lw $2 in EX, add rs=$2 in ID");
    cyc(1, 0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd7, 1, 0, 0);
    nop(5);

    $display("txn: lw $2 in EX, beq rs=$2 in ID");
    cyc(1, 0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 1, 1, 0);
    nop(6);

    $display("txn: load into $0 and rt match with use_rt=0");
    cyc(1, 0, 1, 1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    cyc(1, 0, 1, 1, 5'd4, 0, 5'd0, 5'd1, 5'd4, 0, 0, 0);
    nop(1);

    $display("txn: branch operand hazards from EX ALU and MEM load");
    cyc(1, 0, 0, 1, 5'd3, 0, 5'd0, 5'd3, 5'd0, 1, 1, 0);
    nop(1);
    cyc(1, 0, 0, 0, 5'd0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0);
    nop(2);

    $display("txn: cache miss during DSTALL");
    cyc(1, 0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 1, 0, 0);
    nop(1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    nop(6);

    $display("txn: redirect without and with load-use hazard");
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    nop(1);
    cyc(1, 0, 1, 1, 5'd6, 0, 5'd0, 5'd6, 5'd0, 0, 0, 1);
    nop(4);

    $display("txn: reset during DSTALL");
    cyc(1, 0, 1, 1, 5'd2, 0, 5'd0, 5'd2, 5'd0, 1, 1, 0);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    nop(3);

    $display("txn: 20-cycle cache miss saturates narrow counter");
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    nop(3);

    for (int b = 0; b < 12; b++) begin
      $display("txn: random burst %0d", b);
      for (int i = 0; i < 120; i++) begin
        cyc(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
      end
    end

    nop(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
